traffic_timebase: RTL and testbench

//  Input-conditioning stage directly upstream of the traffic light controller.

---
 rtl/traffic_timebase_pkg.sv | 33 +++
 rtl/traffic_debounce.sv | 49 ++++
 rtl/traffic_timebase.sv | 128 ++++++++++++
 tb/tb_traffic_timebase.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_timebase_pkg.sv
// -----------------------------------------------------------------------------
// traffic_timebase_pkg
//   Shared timing definitions for the traffic light front end. The controller
//   and its bench take CLK_HZ / TICK_HZ from here, so every block derives the
//   same tick divider.
//
//   Contents:
//     DEF_CLK_HZ     system clock frequency (Hz)
//     DEF_TICK_HZ    tick strobe rate (Hz)
//     DEF_DB_CYCLES  clocks a synchronised button must be stable (10 ms)
//     DEF_TCNT_W     width of the tick counter
//     calc_div()     clock divide ratio for a given clock / tick rate
//     cnt_width()    register width able to hold 0 .. n-1 (never below 1)
// -----------------------------------------------------------------------------
package traffic_timebase_pkg;

    localparam int DEF_CLK_HZ    = 100_000_000;
    localparam int DEF_TICK_HZ   = 1;
    localparam int DEF_DB_CYCLES = 1_000_000;
    localparam int DEF_TCNT_W    = 8;

    // Divide ratio between system clock and tick; must come out >= 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter that runs 0 .. n-1. Clamped to one bit so that tiny
    // parameter values still give a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traffic_debounce.sv
// -----------------------------------------------------------------------------
// traffic_debounce
//   Debounces an already-synchronised level. The output only follows the input
//   after the input has held the new level for DB_CYCLES consecutive clocks.
//   Any return to the current output level before then restarts the count.
//   Press and release are treated identically.
//
//   Parameters:
//     DB_CYCLES  stable clocks required to change the output level
//
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   synchronous, active-high reset
//     din_sync  in   synchronised (not debounced) level
//     dout      out  debounced level, registered
// -----------------------------------------------------------------------------
module traffic_debounce
    import traffic_timebase_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din_sync,
    output logic dout
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // cnt == 0 with din_sync == dout is the stable state; any non-zero count
    // means a candidate level change is being timed.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din_sync == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= din_sync;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_timebase.sv
// -----------------------------------------------------------------------------
// traffic_timebase
//   Input conditioning in front of the traffic light controller.
//     - Prescaler: one-clock 'tick' strobe every DIV enabled clocks, with a
//       wrapping count of ticks issued.
//     - Pedestrian button: two-flop synchroniser, debounce, and a request
//       latch that holds a press until the controller acknowledges it.
//   All outputs are registered; there is no combinational input-to-output
//   path.
//
//   Parameters:
//     CLK_HZ     system clock frequency; DIV = CLK_HZ / TICK_HZ (>= 2)
//     TICK_HZ    tick strobe rate
//     DB_CYCLES  debounce stability time in clocks
//     TCNT_W     width of tick_count
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   synchronous, active-high reset (overrides everything)
//     en           in   prescaler enable; low freezes the divider
//     ped_btn_raw  in   asynchronous, bouncing pedestrian button
//     ped_ack      in   one-cycle pulse: controller has serviced the request
//     tick         out  one-clock strobe every DIV enabled clocks
//     tick_count   out  ticks issued, modulo 2^TCNT_W
//     ped_btn_db   out  debounced button level
//     ped_req      out  latched pedestrian request
// -----------------------------------------------------------------------------
module traffic_timebase
    import traffic_timebase_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int TICK_HZ   = DEF_TICK_HZ,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int TCNT_W    = DEF_TCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ped_btn_raw,
    input  logic              ped_ack,
    output logic              tick,
    output logic [TCNT_W-1:0] tick_count,
    output logic              ped_btn_db,
    output logic              ped_req
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int DIV_W = cnt_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    // ------------------------------------------------------------------
    // Prescaler. The tick strobe and its count are registered on the same
    // edge, so tick_count already includes the tick that is currently high.
    // Because div_cnt restarts at 0 after a tick, two ticks are always at
    // least DIV >= 2 clocks apart.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
        end else if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt    <= '0;
                tick       <= 1'b1;
                tick_count <= tick_count + TCNT_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Only sync_s2 is consumed downstream; sync_s1
    // is left to settle out of metastability.
    // ------------------------------------------------------------------
    logic sync_s1;
    logic sync_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= ped_btn_raw;
            sync_s2 <= sync_s1;
        end
    end

    traffic_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .din_sync (sync_s2),
        .dout     (ped_btn_db)
    );

    // ------------------------------------------------------------------
    // Request latch. Only the rising edge of the debounced level sets the
    // request, so holding or releasing the button never adds or clears one.
    // When a new press and an ack coincide, the press wins so it is not lost.
    // ------------------------------------------------------------------
    logic db_prev;
    logic db_rise;

    assign db_rise = ped_btn_db & ~db_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_prev <= 1'b0;
            ped_req <= 1'b0;
        end else begin
            db_prev <= ped_btn_db;
            if (db_rise) begin
                ped_req <= 1'b1;
            end else if (ped_ack) begin
                ped_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_timebase.sv
module tb_traffic_timebase;

    localparam int CLK_HZ    = 10;
    localparam int TICK_HZ   = 1;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int DB_CYCLES = 4;
    localparam int TCNT_W    = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic              ped_btn_raw;
    logic              ped_ack;
    logic              tick;
    logic [TCNT_W-1:0] tick_count;
    logic              ped_btn_db;
    logic              ped_req;

    int checks = 0;
    int errors = 0;

    traffic_timebase #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DB_CYCLES (DB_CYCLES),
        .TCNT_W    (TCNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ped_btn_raw (ped_btn_raw),
        .ped_ack     (ped_ack),
        .tick        (tick),
        .tick_count  (tick_count),
        .ped_btn_db  (ped_btn_db),
        .ped_req     (ped_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model.
    //   tick: the n-th enabled clock since reset ticks when n is a multiple of DIV.
    //   tick_count: number of ticks so far, modulo 2^TCNT_W.
    //   button: the synchronised value is the raw input two clocks late; the
    //   debounced level flips once the last DB_CYCLES synchronised samples all
    //   disagree with it (sliding window). Request is set by a debounced rise,
    //   cleared by an ack that does not coincide with a rise.
    // ------------------------------------------------------------------
    int m_en_edges;
    int m_ticks;
    bit m_tick;
    bit m_s1, m_s2;
    bit m_win[$];
    bit m_db, m_dbp, m_req;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit old_s2, old_db, old_dbp, all_diff;
        if (rst) begin
            m_en_edges = 0;
            m_ticks    = 0;
            m_tick     = 1'b0;
            m_s1       = 1'b0;
            m_s2       = 1'b0;
            m_win      = {};
            for (int i = 0; i < DB_CYCLES; i++) m_win.push_back(1'b0);
            m_db       = 1'b0;
            m_dbp      = 1'b0;
            m_req      = 1'b0;
            m_valid    = 1'b1;
        end else begin
            if (en) begin
                m_en_edges++;
                m_tick = (m_en_edges % DIV == 0);
                if (m_tick) m_ticks++;
            end else begin
                m_tick = 1'b0;
            end
            old_s2  = m_s2;
            old_db  = m_db;
            old_dbp = m_dbp;
            m_s2 = m_s1;
            m_s1 = ped_btn_raw;
            m_win.push_back(old_s2);
            void'(m_win.pop_front());
            all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i] == old_db) all_diff = 1'b0;
            if (all_diff) m_db = !old_db;
            m_dbp = old_db;
            if (old_db && !old_dbp) m_req = 1'b1;
            else if (ped_ack)       m_req = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("tick",       int'(tick),       int'(m_tick));
            check("tick_count", int'(tick_count), m_ticks % (1 << TCNT_W));
            check("ped_btn_db", int'(ped_btn_db), int'(m_db));
            check("ped_req",    int'(ped_req),    int'(m_req));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int n);
        ped_btn_raw = 1'b1;
        wait_clks(n);
        ped_btn_raw = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        ped_btn_raw = 1'b0;
        ped_ack     = 1'b0;

        // 1: reset, then first tick on the 10th enabled edge, then every 10
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_rst_tick",  int'(tick),       0);
            check("t1_rst_count", int'(tick_count), 0);
            check("t1_rst_req",   int'(ped_req),    0);
        end
        rst = 1'b0;
        en  = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            check("t1_tick",  int'(tick),       (e % 10 == 0) ? 1 : 0);
            check("t1_count", int'(tick_count), e / 10);
        end

        // 2: freeze divider for 5 clocks at div_cnt=6; tick lands on edge 45
        wait_clks(6);
        en = 1'b0;
        wait_clks(5);
        en = 1'b1;
        wait_clks(3);
        check("t2_no_early_tick", int'(tick), 0);
        @(negedge clk);
        check("t2_late_tick",  int'(tick),       1);
        check("t2_late_count", int'(tick_count), 4);
        @(negedge clk);
        check("t2_tick_width", int'(tick), 0);

        // 3: bounce shorter than the debounce window
        press(3);
        wait_clks(2);
        press(2);
        wait_clks(10);
        check("t3_db",  int'(ped_btn_db), 0);
        check("t3_req", int'(ped_req),    0);

        // 4: clean press; db after edge 6, req after edge 7
        ped_btn_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (e == 5) check("t4_db_e5",  int'(ped_btn_db), 0);
            if (e == 6) check("t4_db_e6",  int'(ped_btn_db), 1);
            if (e == 6) check("t4_req_e6", int'(ped_req),    0);
            if (e == 7) check("t4_req_e7", int'(ped_req),    1);
        end
        ped_btn_raw = 1'b0;
        wait_clks(10);
        check("t4_db_released", int'(ped_btn_db), 0);
        check("t4_req_held",    int'(ped_req),    1);
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        check("t4_req_acked", int'(ped_req), 0);
        wait_clks(5);
        check("t4_no_second_req", int'(ped_req), 0);

        // 5: ack collides with a new debounced rise
        press(8);
        wait_clks(10);
        check("t5_req_pre", int'(ped_req), 1);
        ped_btn_raw = 1'b1;
        wait_clks(6);
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        check("t5_collision_req", int'(ped_req), 1);
        wait_clks(5);
        ped_btn_raw = 1'b0;
        wait_clks(10);
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        check("t5_lone_ack", int'(ped_req), 0);
        ped_ack = 1'b1;
        @(negedge clk);
        ped_ack = 1'b0;
        check("t5_idle_ack", int'(ped_req), 0);

        // 6: reset with div_cnt=6 and a pending request, then counter wrap
        press(8);
        wait_clks(10);
        for (int k = 0; k < DIV && (m_en_edges % DIV) != 6; k++) @(negedge clk);
        check("t6_req_pre", int'(ped_req), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_tick",  int'(tick),       0);
        check("t6_rst_count", int'(tick_count), 0);
        check("t6_rst_req",   int'(ped_req),    0);
        for (int e = 1; e <= 2560; e++) begin
            @(negedge clk);
            if (e == 9)    check("t6_tick_e9",    int'(tick),       0);
            if (e == 10)   check("t6_tick_e10",   int'(tick),       1);
            if (e == 10)   check("t6_count_e10",  int'(tick_count), 1);
            if (e == 2550) check("t6_count_255",  int'(tick_count), 255);
            if (e == 2560) check("t6_count_wrap", int'(tick_count), 0);
            if (e == 2560) check("t6_tick_wrap",  int'(tick),       1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
